display_source_arbiter: RTL and testbench
=========================================

DISPLAY_SOURCE_ARBITER -- requirements
Module: display_source_arbiter

Interface
REQ-001 The block SHALL have parameter CLK_IN, default 5000000, meaning input clock frequency in Hz.
REQ-002 The block SHALL have parameter BLINK_HZ, default 2, meaning the blink rate in full on/off cycles per second.
REQ-003 The block SHALL have parameter PEEK_SEC, default 3, meaning the alarm-peek display duration in seconds.
REQ-004 Port i_Clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 Port i_Reset  input  1  SHALL be an asynchronous, active-low reset.
REQ-006 Port i_Time_BCD  input  16  SHALL carry the current time as 4 BCD digits HHMM; digit 3 is in [15:12].
REQ-007 Port i_Alarm_BCD  input  16  SHALL carry the stored alarm time, in the same format.
REQ-008 Port i_Set_BCD  input  16  SHALL carry the value being edited, in the same format.
REQ-009 Port i_Set_Active  input  1  SHALL be a level input; 1 means set mode is active.
REQ-010 Port i_Set_Field  input  1  SHALL select the edited field: 0 = hours (digits 3:2), 1 = minutes (digits 1:0).
REQ-011 Port i_Ringing  input  1  SHALL be a level input; 1 means the alarm is sounding.
REQ-012 Port i_Peek_Req  input  1  SHALL be a single-cycle pulse requesting a temporary alarm-time display.
REQ-013 Port o_BCD_Num  output  16  SHALL carry the BCD value sent to the seven-segment driver.
REQ-014 Port o_Blank_Mask  output  4  SHALL blank digit i when bit i is 1.
REQ-015 Port o_Source  output  2  SHALL report the current state: 0 = TIME, 1 = PEEK, 2 = RING, 3 = SET.

Function
REQ-016 The FSM SHALL have the states TIME, PEEK, RING and SET.
REQ-017 Each cycle, the next state SHALL be selected by priority: SET if i_Set_Active; else RING if i_Ringing; else PEEK if i_Peek_Req or (state==PEEK and peek counter not expired); else TIME.
REQ-018 The PEEK counter SHALL load with PEEK_SEC*CLK_IN-1 on i_Peek_Req and decrement by 1 per cycle while in PEEK; expiry is count==0.
REQ-019 A PEEK that reaches expiry SHALL return to TIME on the next cycle.
REQ-020 An i_Peek_Req received while in PEEK SHALL reload the PEEK counter, extending the peek.
REQ-021 An i_Peek_Req received while in SET or RING SHALL be ignored, and the PEEK counter SHALL NOT load.
REQ-022 On leaving PEEK for SET or RING, the peek SHALL be abandoned, with no return to PEEK afterwards.
REQ-023 The blink timer SHALL count CLK_IN/(2*BLINK_HZ) cycles per half-period, using integer division, and toggle a phase bit at each terminal count.
REQ-024 On every state transition, the blink timer SHALL clear to 0 and the phase SHALL clear to 0 (visible).
REQ-025 o_BCD_Num SHALL be i_Time_BCD in TIME and RING, i_Alarm_BCD in PEEK, and i_Set_BCD in SET.
REQ-026 o_Blank_Mask SHALL be 4'b0000 in TIME and PEEK.
REQ-027 In RING, o_Blank_Mask SHALL be 4'b1111 when phase=1 and 4'b0000 when phase=0.
REQ-028 In SET with phase=1, o_Blank_Mask SHALL be 4'b1100 when i_Set_Field=0 and 4'b0011 when i_Set_Field=1.
REQ-029 In SET with phase=0, o_Blank_Mask SHALL be 4'b0000.
REQ-030 A change of i_Set_Field while in SET SHALL clear the blink timer and phase.
REQ-031 All outputs SHALL be registered, with one cycle of latency from the inputs and state to the outputs.
REQ-032 o_Source SHALL change in the same cycle as o_BCD_Num reflects the new source.
REQ-033 No output SHALL ever present a value mixed from two sources.

Reset
REQ-034 When i_Reset=0, the block SHALL immediately force state TIME, clear the PEEK counter, blink timer and phase, and drive o_BCD_Num=16'h0000, o_Blank_Mask=4'b0000 and o_Source=0, asynchronously to i_Clk.
REQ-035 A reset asserted mid-PEEK or mid-blink SHALL abandon that operation; after release, the first rising edge SHALL evaluate priority from a clean TIME state.

Verification (bench parameters: CLK_IN=20, BLINK_HZ=2, PEEK_SEC=1; half-period = 5 cycles, peek = 20 cycles)
REQ-036 Scenario: idle with i_Time_BCD=16'h1259 -> o_BCD_Num=16'h1259, o_Blank_Mask=0 and o_Source=0 one cycle after the input settles.
REQ-037 Scenario: i_Alarm_BCD=16'h0630 and a single i_Peek_Req pulse -> o_BCD_Num=16'h0630 and o_Source=1 for exactly 20 cycles, then back to 16'h1259; a second pulse at cycle 15 extends the peek to 35 cycles total.
REQ-038 Scenario: i_Set_Active=1, i_Set_Field=1, i_Set_BCD=16'h0745 -> o_Source=3 and o_Blank_Mask alternating 0000 and 0011 every 5 cycles, starting visible; toggling i_Set_Field restarts the pattern visible with mask 1100.
REQ-039 Scenario: i_Ringing=1 -> o_Blank_Mask alternating 0000 and 1111 every 5 cycles; asserting i_Set_Active during RING switches to SET on the next cycle with phase visible.
REQ-040 Scenario: i_Reset=0 asserted mid-PEEK between clock edges -> outputs reach their reset values before the next edge; after release with no request, o_Source=0.
REQ-041 Scenario: i_Peek_Req during SET, then i_Set_Active falls -> the block goes to TIME, not PEEK.

Source files
------------

// File: rtl/display_source_arbiter_if.sv
// Signal bundle between the clock/alarm datapath and the display source arbiter.
// Plain level/pulse signals with no backpressure: the arbiter samples every input on each rising clock edge.
interface display_source_arbiter_if;
    logic [15:0] i_Time_BCD;
    logic [15:0] i_Alarm_BCD;
    logic [15:0] i_Set_BCD;
    logic        i_Set_Active;
    logic        i_Set_Field;
    logic        i_Ringing;
    logic        i_Peek_Req;
    logic [15:0] o_BCD_Num;
    logic [3:0]  o_Blank_Mask;
    logic [1:0]  o_Source;

    modport master (
        output i_Time_BCD, i_Alarm_BCD, i_Set_BCD, i_Set_Active, i_Set_Field, i_Ringing, i_Peek_Req,
        input  o_BCD_Num, o_Blank_Mask, o_Source
    );

    modport slave (
        input  i_Time_BCD, i_Alarm_BCD, i_Set_BCD, i_Set_Active, i_Set_Field, i_Ringing, i_Peek_Req,
        output o_BCD_Num, o_Blank_Mask, o_Source
    );
endinterface

// File: rtl/display_source_arbiter.sv
// Chooses which BCD value (time, alarm peek, set value) drives the seven-segment display,
// and generates the blink masks for ringing and set mode. All outputs are registered.
module display_source_arbiter #(
    parameter int CLK_IN   = 5000000,
    parameter int BLINK_HZ = 2,
    parameter int PEEK_SEC = 3
) (
    input  logic                     i_Clk,
    input  logic                     i_Reset,
    display_source_arbiter_if.slave  bus
);
    localparam int HALF_RAW = CLK_IN / (2 * BLINK_HZ);
    localparam int HALF_CYC = (HALF_RAW < 1) ? 1 : HALF_RAW;
    localparam int BLINK_W  = (HALF_CYC > 1) ? $clog2(HALF_CYC) : 1;
    localparam int PEEK_CYC = PEEK_SEC * CLK_IN;
    localparam int PEEK_W   = (PEEK_CYC > 1) ? $clog2(PEEK_CYC) : 1;

    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(HALF_CYC - 1);
    localparam logic [PEEK_W-1:0]  PEEK_LOAD  = PEEK_W'(PEEK_CYC - 1);

    // Encoding doubles as the o_Source code, so the state register is the debug view.
    typedef enum logic [1:0] {
        S_TIME = 2'd0,
        S_PEEK = 2'd1,
        S_RING = 2'd2,
        S_SET  = 2'd3
    } state_t;

    state_t               state, state_next;
    logic [PEEK_W-1:0]    peek_cnt, peek_cnt_next;
    logic [BLINK_W-1:0]   blink_cnt, blink_cnt_next;
    logic                 phase, phase_next;
    logic                 field_q;
    logic                 restart;
    logic [15:0]          bcd_q, bcd_next;
    logic [3:0]           mask_q, mask_next;

    always_comb begin
        state_next     = S_TIME;
        peek_cnt_next  = peek_cnt;
        blink_cnt_next = blink_cnt;
        phase_next     = phase;
        restart        = 1'b0;
        bcd_next       = bus.i_Time_BCD;
        mask_next      = 4'b0000;

        if (bus.i_Set_Active)
            state_next = S_SET;
        else if (bus.i_Ringing)
            state_next = S_RING;
        else if (bus.i_Peek_Req || (state == S_PEEK && peek_cnt != '0))
            state_next = S_PEEK;

        // A request only loads when PEEK actually wins priority; leaving PEEK discards the count.
        if (bus.i_Peek_Req && !bus.i_Set_Active && !bus.i_Ringing)
            peek_cnt_next = PEEK_LOAD;
        else if (state_next != S_PEEK)
            peek_cnt_next = '0;
        else if (peek_cnt != '0)
            peek_cnt_next = peek_cnt - 1'b1;

        restart = (state_next != state) ||
                  (state == S_SET && state_next == S_SET && bus.i_Set_Field != field_q);
        if (restart) begin
            blink_cnt_next = '0;
            phase_next     = 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt_next = '0;
            phase_next     = ~phase;
        end else begin
            blink_cnt_next = blink_cnt + 1'b1;
        end

        case (state_next)
            S_PEEK: bcd_next = bus.i_Alarm_BCD;
            S_SET: begin
                bcd_next = bus.i_Set_BCD;
                if (phase_next)
                    mask_next = bus.i_Set_Field ? 4'b0011 : 4'b1100;
            end
            S_RING: mask_next = phase_next ? 4'b1111 : 4'b0000;
            default: bcd_next = bus.i_Time_BCD;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Reset) begin
        if (!i_Reset) begin
            state     <= S_TIME;
            peek_cnt  <= '0;
            blink_cnt <= '0;
            phase     <= 1'b0;
            field_q   <= 1'b0;
            bcd_q     <= 16'h0000;
            mask_q    <= 4'b0000;
        end else begin
            state     <= state_next;
            peek_cnt  <= peek_cnt_next;
            blink_cnt <= blink_cnt_next;
            phase     <= phase_next;
            field_q   <= bus.i_Set_Field;
            bcd_q     <= bcd_next;
            mask_q    <= mask_next;
        end
    end

    assign bus.o_BCD_Num    = bcd_q;
    assign bus.o_Blank_Mask = mask_q;
    assign bus.o_Source     = state;
endmodule

// File: tb/tb_display_source_arbiter.sv
// Directed vector table plus hand-written multi-cycle sequences for the display source arbiter.
module tb_display_source_arbiter;
    logic i_Clk;
    logic i_Reset;
    int   n_checks;
    int   n_fail;

    display_source_arbiter_if bus ();

    display_source_arbiter #(
        .CLK_IN   (20),
        .BLINK_HZ (2),
        .PEEK_SEC (1)
    ) dut (
        .i_Clk   (i_Clk),
        .i_Reset (i_Reset),
        .bus     (bus)
    );

    initial begin
        i_Clk = 1'b0;
        forever #5 i_Clk = ~i_Clk;
    end

    typedef struct {
        logic [15:0] tm;
        logic [15:0] al;
        logic [15:0] st;
        logic        sa;
        logic        sf;
        logic        rg;
        logic        pk;
        logic [15:0] e_bcd;
        logic [3:0]  e_mask;
        logic [1:0]  e_src;
    } vec_t;

    vec_t vecs[13];

    task automatic tick();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [15:0] b, input logic [3:0] m, input logic [1:0] s);
        n_checks++;
        if (bus.o_BCD_Num !== b || bus.o_Blank_Mask !== m || bus.o_Source !== s) begin
            n_fail++;
            $display("FAIL %s: got bcd=%h mask=%b src=%0d, expected bcd=%h mask=%b src=%0d",
                     nm, bus.o_BCD_Num, bus.o_Blank_Mask, bus.o_Source, b, m, s);
        end
    endtask

    task automatic drive(input logic [15:0] tm, input logic [15:0] al, input logic [15:0] st,
                         input logic sa, input logic sf, input logic rg, input logic pk);
        bus.i_Time_BCD   = tm;
        bus.i_Alarm_BCD  = al;
        bus.i_Set_BCD    = st;
        bus.i_Set_Active = sa;
        bus.i_Set_Field  = sf;
        bus.i_Ringing    = rg;
        bus.i_Peek_Req   = pk;
    endtask

    initial begin
        logic [3:0] em;
        n_checks = 0;
        n_fail   = 0;

        //            time      alarm     set       sa    sf    rg    pk    bcd       mask     src
        vecs[0]  = '{16'h1259, 16'h0630, 16'h0745, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1259, 4'b0000, 2'd0};
        vecs[1]  = '{16'h1300, 16'h0630, 16'h0745, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1300, 4'b0000, 2'd0};
        vecs[2]  = '{16'h1300, 16'h0630, 16'h0745, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0745, 4'b0000, 2'd3};
        vecs[3]  = '{16'h1300, 16'h0630, 16'h0745, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0745, 4'b0000, 2'd3};
        vecs[4]  = '{16'h1259, 16'h0630, 16'h0745, 1'b0, 1'b1, 1'b1, 1'b0, 16'h1259, 4'b0000, 2'd2};
        vecs[5]  = '{16'h1259, 16'h0630, 16'h0745, 1'b0, 1'b1, 1'b1, 1'b1, 16'h1259, 4'b0000, 2'd2};
        vecs[6]  = '{16'h1259, 16'h0630, 16'h0745, 1'b0, 1'b1, 1'b0, 1'b0, 16'h1259, 4'b0000, 2'd0};
        vecs[7]  = '{16'h1259, 16'h0630, 16'h0745, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0630, 4'b0000, 2'd1};
        vecs[8]  = '{16'h1259, 16'h0630, 16'h0745, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0745, 4'b0000, 2'd3};
        vecs[9]  = '{16'h1259, 16'h0630, 16'h0745, 1'b0, 1'b1, 1'b0, 1'b0, 16'h1259, 4'b0000, 2'd0};
        vecs[10] = '{16'h1259, 16'h0915, 16'h0745, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0915, 4'b0000, 2'd1};
        vecs[11] = '{16'h1259, 16'h0915, 16'h0745, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1259, 4'b0000, 2'd2};
        vecs[12] = '{16'h1259, 16'h0630, 16'h0745, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1259, 4'b0000, 2'd0};

        // Reset values appear before any clock edge.
        i_Reset = 1'b0;
        drive(16'h1259, 16'h0630, 16'h0745, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        check("reset_async", 16'h0000, 4'b0000, 2'd0);
        tick();
        tick();
        check("reset_held", 16'h0000, 4'b0000, 2'd0);
        i_Reset = 1'b1;

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].tm, vecs[i].al, vecs[i].st, vecs[i].sa, vecs[i].sf, vecs[i].rg, vecs[i].pk);
            tick();
            check($sformatf("vec%0d", i), vecs[i].e_bcd, vecs[i].e_mask, vecs[i].e_src);
        end

        // Single peek: exactly 20 cycles of alarm display.
        for (int i = 0; i <= 20; i++) begin
            bus.i_Peek_Req = (i == 0);
            tick();
            bus.i_Peek_Req = 1'b0;
            if (i < 20) check($sformatf("peek_single_c%0d", i), 16'h0630, 4'b0000, 2'd1);
            else        check("peek_single_end", 16'h1259, 4'b0000, 2'd0);
        end

        // Second pulse at cycle 15 extends the peek to 35 cycles.
        for (int i = 0; i <= 35; i++) begin
            bus.i_Peek_Req = (i == 0 || i == 15);
            tick();
            bus.i_Peek_Req = 1'b0;
            if (i < 35) check($sformatf("peek_ext_c%0d", i), 16'h0630, 4'b0000, 2'd1);
            else        check("peek_ext_end", 16'h1259, 4'b0000, 2'd0);
        end

        // SET minutes field blinks 0000/0011, then a field toggle restarts visible with 1100.
        drive(16'h1259, 16'h0630, 16'h0745, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 13; i++) begin
            tick();
            em = ((i / 5) % 2 == 1) ? 4'b0011 : 4'b0000;
            check($sformatf("set_min_c%0d", i), 16'h0745, em, 2'd3);
        end
        bus.i_Set_Field = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            em = ((i / 5) % 2 == 1) ? 4'b1100 : 4'b0000;
            check($sformatf("set_hr_c%0d", i), 16'h0745, em, 2'd3);
        end

        drive(16'h1259, 16'h0630, 16'h0745, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check("idle_before_ring", 16'h1259, 4'b0000, 2'd0);

        // RING blinks all digits; SET during RING takes over next cycle, visible.
        bus.i_Ringing = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            em = ((i / 5) % 2 == 1) ? 4'b1111 : 4'b0000;
            check($sformatf("ring_c%0d", i), 16'h1259, em, 2'd2);
        end
        bus.i_Set_Active = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            em = ((i / 5) % 2 == 1) ? 4'b1100 : 4'b0000;
            check($sformatf("ring_to_set_c%0d", i), 16'h0745, em, 2'd3);
        end

        drive(16'h1259, 16'h0630, 16'h0745, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check("idle_before_rst", 16'h1259, 4'b0000, 2'd0);

        // Reset asserted between edges in the middle of a peek.
        bus.i_Peek_Req = 1'b1;
        tick();
        bus.i_Peek_Req = 1'b0;
        tick();
        tick();
        check("peek_before_rst", 16'h0630, 4'b0000, 2'd1);
        #2;
        i_Reset = 1'b0;
        #1;
        check("rst_mid_peek", 16'h0000, 4'b0000, 2'd0);
        tick();
        check("rst_mid_peek_held", 16'h0000, 4'b0000, 2'd0);
        i_Reset = 1'b1;
        tick();
        check("after_rst_release", 16'h1259, 4'b0000, 2'd0);
        tick();
        check("after_rst_idle", 16'h1259, 4'b0000, 2'd0);

        // Peek request during SET is dropped; leaving SET lands in TIME.
        bus.i_Set_Active = 1'b1;
        tick();
        check("set_enter", 16'h0745, 4'b0000, 2'd3);
        bus.i_Peek_Req = 1'b1;
        tick();
        bus.i_Peek_Req = 1'b0;
        check("set_peek_ignored", 16'h0745, 4'b0000, 2'd3);
        bus.i_Set_Active = 1'b0;
        tick();
        check("set_exit_time", 16'h1259, 4'b0000, 2'd0);
        tick();
        check("set_exit_stays_time", 16'h1259, 4'b0000, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
